// File: rtl/mem_read_scheduler_pkg.sv
// Shared types and helpers for the memory read/write schedulers.
// Optional perf counters are enabled with MEM_READ_SCHED_PERF_EN.
package mem_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

    localparam int PERF_CNT_W = 16;

    // Width of an index into n clients; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_read_scheduler_if.sv
// Client-side request/response bus plus the memory read port of the scheduler.
// Handshake: a request of client i is accepted in a cycle where r_avalid[i] and
// r_aready[i] are both high at posedge clk; r_aready never rises without r_avalid,
// and r_dvalid has no backpressure (the client must take the data that cycle).
interface mem_read_scheduler_if #(
    parameter int REQUESTERS = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] r_addr;
    logic [REQUESTERS-1:0]                 r_avalid;
    logic [REQUESTERS-1:0]                 r_aready;
    logic [REQUESTERS-1:0]                 r_dvalid;
    logic [REQUESTERS-1:0][DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0]                 mem_r_addr;
    logic                                  mem_r_avalid;
    logic [DATA_WIDTH-1:0]                 mem_r_data;

    modport slave (
        input  r_addr, r_avalid, mem_r_data,
        output r_aready, r_dvalid, r_data, mem_r_addr, mem_r_avalid
    );

    modport master (
        output r_addr, r_avalid, mem_r_data,
        input  r_aready, r_dvalid, r_data, mem_r_addr, mem_r_avalid
    );
endinterface

// File: rtl/mem_read_scheduler_picker.sv
// Combinational circular priority picker: first set bit of req at or after start.
// Shared by the read- and write-side schedulers.
module rr_priority_picker
    import mem_sched_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          found
);
    int pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) + k;
            if (pos >= N) pos = pos - N;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IW'(pos);
            end
        end
    end
endmodule

// File: rtl/mem_read_scheduler.sv
// Round-robin read-port scheduler with bounded bursts and a one-hot owner-ID
// return pipeline. Define MEM_READ_SCHED_PERF_EN to add per-client grant counters.
module mem_read_scheduler
    import mem_sched_pkg::*;
#(
    parameter int REQUESTERS = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_BURST  = 4,
    localparam int IDX_W     = idx_w(REQUESTERS),
    localparam int BEAT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                clk,
    input  logic                rst,
    mem_read_scheduler_if.slave bus,
    output sched_state_t        dbg_state,
    output logic [IDX_W-1:0]    dbg_owner,
    output logic [IDX_W-1:0]    dbg_ptr
`ifdef MEM_READ_SCHED_PERF_EN
    ,
    output logic [REQUESTERS-1:0][PERF_CNT_W-1:0] perf_grants
`endif
);
    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t next_idx(input idx_t i);
        return (i == idx_t'(REQUESTERS - 1)) ? '0 : i + 1'b1;
    endfunction

    sched_state_t              state_q, state_d;
    idx_t                      owner_q, owner_d;
    idx_t                      ptr_q, ptr_d;
    logic [BEAT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0]     mem_r_addr_q, mem_r_addr_d;
    logic                      mem_r_avalid_q, mem_r_avalid_d;
    logic [MEM_LAT:0][REQUESTERS-1:0] id_pipe_q, id_pipe_d;

    logic                      cont;
    idx_t                      scan_start;
    logic [REQUESTERS-1:0]     pick_gnt;
    idx_t                      pick_idx;
    logic                      pick_found;
    logic [REQUESTERS-1:0]     aready;
    idx_t                      win_idx;
    logic                      accept;

    // The previous owner lands last in the scan, so it only wins when alone.
    assign scan_start = (state_q == BURST) ? next_idx(owner_q) : ptr_q;

    rr_priority_picker #(
        .N  (REQUESTERS),
        .IW (IDX_W)
    ) u_picker (
        .req   (bus.r_avalid),
        .start (scan_start),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        cont    = (state_q == BURST) && bus.r_avalid[owner_q] &&
                  (beat_cnt_q < BEAT_W'(MAX_BURST));
        aready  = '0;
        win_idx = pick_idx;
        if (!rst) begin
            if (cont) begin
                aready[owner_q] = 1'b1;
                win_idx         = owner_q;
            end else begin
                aready = pick_gnt;
            end
        end
        accept = |aready;
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        ptr_d          = ptr_q;
        beat_cnt_d     = beat_cnt_q;
        if (cont) begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end else if (pick_found) begin
            state_d    = BURST;
            owner_d    = pick_idx;
            ptr_d      = next_idx(pick_idx);
            beat_cnt_d = BEAT_W'(1);
        end else begin
            state_d    = IDLE;
        end
        mem_r_avalid_d = accept;
        mem_r_addr_d   = accept ? bus.r_addr[win_idx] : mem_r_addr_q;
        id_pipe_d      = {id_pipe_q[MEM_LAT-1:0], aready};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= '0;
            ptr_q          <= '0;
            beat_cnt_q     <= '0;
            mem_r_addr_q   <= '0;
            mem_r_avalid_q <= 1'b0;
            id_pipe_q      <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            ptr_q          <= ptr_d;
            beat_cnt_q     <= beat_cnt_d;
            mem_r_addr_q   <= mem_r_addr_d;
            mem_r_avalid_q <= mem_r_avalid_d;
            id_pipe_q      <= id_pipe_d;
        end
    end

    assign bus.r_aready     = aready;
    assign bus.mem_r_addr   = mem_r_addr_q;
    assign bus.mem_r_avalid = mem_r_avalid_q;
    assign bus.r_dvalid     = id_pipe_q[MEM_LAT];
    assign dbg_state        = state_q;
    assign dbg_owner        = owner_q;
    assign dbg_ptr          = ptr_q;

    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) bus.r_data[i] = bus.mem_r_data;
    end

`ifdef MEM_READ_SCHED_PERF_EN
    logic [REQUESTERS-1:0][PERF_CNT_W-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (aready[i] && (perf_q[i] != {PERF_CNT_W{1'b1}}))
                perf_d[i] = perf_q[i] + PERF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_grants = perf_q;
`endif
endmodule
